code_mem_loader: RTL and testbench
==================================

CODE_MEM_LOADER -- requirements
Module: code_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, memory is zero-filled after reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rd_addr, input, ADDR_W, read address.
REQ-007 SHALL have port rd_data, output, DATA_W, registered read data.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_W) and wr_data (input, DATA_W), forming the direct single-word write port.
REQ-009 SHALL have ports load_start (input, 1), load_base (input, ADDR_W) and load_count (input, ADDR_W+1), the loader command.
REQ-010 SHALL have ports in_byte (input, 8), in_valid (input, 1) and in_ready (output, 1), the byte-stream handshake.
REQ-011 SHALL have port load_abort, input, 1, which cancels an active load.
REQ-012 SHALL have port busy, output, 1, high in CLEAR or LOAD.
REQ-013 SHALL have ports load_done (output, 1, one-cycle pulse) and wr_reject (output, 1, one-cycle pulse).
REQ-014 SHALL have port load_sum, output, DATA_W, modulo-2**DATA_W sum of the words written by the current or most recent load.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR and LOAD.
REQ-016 Read: rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is sampled, in every state.
REQ-017 Read-during-write to the same address SHALL return the old data; the new data is visible on the next cycle.
REQ-018 In IDLE with wr_en=1, SHALL write wr_data to mem[wr_addr].
REQ-019 wr_en=1 while busy SHALL be ignored, with wr_reject pulsed in the same cycle.
REQ-020 IDLE with load_start=1 SHALL go to LOAD: write pointer <= load_base, word count <= load_count, load_sum <= 0, byte index <= 0.
REQ-021 load_start with load_count=0 SHALL stay in IDLE, pulse load_done next cycle, and clear load_sum.
REQ-022 If load_start and wr_en are both high in IDLE, the direct write SHALL complete and the load SHALL start in the same cycle.
REQ-023 load_start while busy SHALL be ignored.
REQ-024 in_ready SHALL be 1 only in LOAD; a byte is accepted when in_valid and in_ready are both 1.
REQ-025 Bytes SHALL be assembled little-endian: the first byte goes to bits [7:0]; DATA_W/8 bytes form one word.
REQ-026 On acceptance of the final byte of a word, SHALL write the word to mem[pointer] in that cycle, add it to load_sum, increment the pointer modulo DEPTH (wrap from DEPTH-1 to 0), and decrement the count.
REQ-027 When the count reaches 0, SHALL return to IDLE and pulse load_done in the next cycle.
REQ-028 in_valid in IDLE or CLEAR SHALL be ignored (in_ready=0).
REQ-029 load_abort in LOAD SHALL return to IDLE, discard the partial word and not pulse load_done; words already written SHALL remain.
REQ-030 load_abort SHALL take priority over byte acceptance in the same cycle.
REQ-031 load_abort outside LOAD SHALL be ignored.
REQ-032 CLEAR SHALL write zero to addresses 0..DEPTH-1, one per cycle, then go to IDLE; it takes DEPTH cycles.
REQ-033 Reads in CLEAR SHALL follow REQ-016/REQ-017.

Reset
REQ-034 On reset, SHALL set rd_data=0, load_sum=0, load_done=0, wr_reject=0 and byte index=0.
REQ-035 On reset, the state SHALL become CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; busy follows the state.
REQ-036 Reset asserted mid-LOAD or mid-CLEAR SHALL abandon the operation without a load_done pulse.
REQ-037 With CLEAR_ON_RESET=0, memory contents SHALL be unaffected by reset.

Structure
REQ-038 State encoding and DATA_W/ADDR_W defaults SHALL live in the shared CPU package.
REQ-039 The byte assembler (index counter plus shift register) SHALL be one sub-module, byte_packer.
REQ-040 Memory SHALL be a single array with one write port and one registered read port.

Verification
REQ-041 Reset with CLEAR_ON_RESET=1 -> busy=1 for 64 cycles; then rd_addr=17 gives rd_data=0x0000.
REQ-042 Direct write wr_addr=5, wr_data=0xA1B2, with a same-cycle read of addr 5 -> old data; next cycle -> 0xA1B2.
REQ-043 load_base=62, load_count=3, bytes 01 00 02 00 03 00 -> mem[62]=1, mem[63]=2, mem[0]=3; load_sum=6; one load_done pulse.
REQ-044 in_valid toggled randomly during a load -> only handshaken bytes are accepted; the result is identical to REQ-043.
REQ-045 load_abort after 3 bytes of a 2-word load -> only the first word is written; no load_done; wr_reject pulses on a wr_en during the load.
REQ-046 Reset mid-load after 1 word -> state IDLE/CLEAR per the parameter, load_sum=0, no load_done pulse.

Source files
------------

// File: rtl/code_mem_loader_pkg.sv
// Shared definitions for the code memory loader: default widths and FSM states.
package code_mem_loader_pkg;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;
endpackage

// File: rtl/code_mem_loader_byte_packer.sv
// Little-endian byte assembler: collects DATA_W/8 bytes into one word.
module byte_packer
  import code_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0] idx;

  assign word_done = accept && (idx == IDX_W'(BYTES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear)
      idx <= '0;
    else if (accept)
      idx <= word_done ? '0 : idx + IDX_W'(1);
  end

  generate
    if (BYTES == 1) begin : g_single
      assign word = in_byte;
    end else begin : g_multi
      // Bytes enter at the top and shift down, so the first byte lands in [7:0].
      logic [DATA_W-9:0] shreg;
      always_ff @(posedge clock) begin
        if (reset || clear)
          shreg <= '0;
        else if (accept)
          shreg <= word[DATA_W-1:8];
      end
      assign word = {in_byte, shreg};
    end
  endgenerate
endmodule

// File: rtl/code_mem_loader.sv
// Instruction memory with direct write port, byte-stream loader and optional clear after reset.
module code_mem_loader
  import code_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_abort,
  output logic              busy,
  output logic              load_done,
  output logic              wr_reject,
  output logic [DATA_W-1:0] load_sum
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, ptr;
  logic [ADDR_W:0]   count;
  logic              accept, pack_clear, word_done;
  logic [DATA_W-1:0] word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pack_clear),
    .accept    (accept),
    .in_byte   (in_byte),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (load_start && load_count != '0) state_nx = ST_LOAD;
      ST_CLEAR: if (clr_ptr == '1) state_nx = ST_IDLE;
      ST_LOAD: begin
        if (load_abort)
          state_nx = ST_IDLE;
        else if (word_done && count == (ADDR_W+1)'(1))
          state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    in_ready   = (state == ST_LOAD);
    accept     = in_ready && in_valid && !load_abort;
    pack_clear = (state == ST_IDLE && load_start) || (state == ST_LOAD && load_abort);
    wr_reject  = wr_en && busy && !reset;
    mem_we     = 1'b0;
    mem_wa     = wr_addr;
    mem_wd     = wr_data;
    case (state)
      ST_IDLE:  mem_we = wr_en;
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
      end
      ST_LOAD: begin
        mem_we = word_done;
        mem_wa = ptr;
        mem_wd = word;
      end
      default:  mem_we = 1'b0;
    endcase
    if (reset)
      mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clr_ptr   <= '0;
      ptr       <= '0;
      count     <= '0;
      load_sum  <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (state == ST_CLEAR)
        clr_ptr <= clr_ptr + ADDR_W'(1);
      if (state == ST_IDLE && load_start) begin
        ptr       <= load_base;
        count     <= load_count;
        load_sum  <= '0;
        load_done <= (load_count == '0);
      end
      if (state == ST_LOAD && word_done) begin
        ptr       <= ptr + ADDR_W'(1);
        count     <= count - (ADDR_W+1)'(1);
        load_sum  <= load_sum + word;
        load_done <= (count == (ADDR_W+1)'(1));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  // Non-blocking read of the array returns pre-write data on a same-address collision.
  always_ff @(posedge clock) begin
    if (reset)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_code_mem_loader.sv
// Self-checking bench for code_mem_loader against an array-based memory model.
module tb_code_mem_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        load_start = 1'b0;
  logic [5:0]  load_base = '0;
  logic [6:0]  load_count = '0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_abort = 1'b0;
  logic        busy, load_done, wr_reject;
  logic [15:0] load_sum;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int rej_cnt = 0;
  logic [15:0] mem_m [64];
  logic [7:0]  byte_q [$];

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } wr_vec_t;
  wr_vec_t vecs [8];

  always #5 clock = ~clock;

  code_mem_loader #(.DATA_W(16), .ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .load_abort(load_abort), .busy(busy), .load_done(load_done),
    .wr_reject(wr_reject), .load_sum(load_sum)
  );

  always @(negedge clock) begin
    if (load_done) done_cnt++;
    if (wr_reject) rej_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic read_all(input string name);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      tick;
      check(name, rd_data, mem_m[a]);
    end
  endtask

  task automatic wait_clear;
    int n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    check("clear_cycles", n, 64);
    for (int a = 0; a < 64; a++) mem_m[a] = '0;
  endtask

  task automatic run_load(input logic [5:0] base, input logic [6:0] cnt,
                          input int abort_at, input bit rnd, input bit poke);
    int sent, guard, d0, r0, nacc, nw;
    logic [15:0] sum;
    logic [5:0]  a;
    bit poked, ok;
    sent = 0; guard = 0; poked = 0; d0 = done_cnt; r0 = rej_cnt;
    load_base = base; load_count = cnt; load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("in_ready_load", in_ready, 1);
    while (sent < byte_q.size() && guard < 2000) begin
      guard++;
      in_byte  = byte_q[sent];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && !poked && sent == 1) begin
        wr_en = 1'b1; wr_addr = base + 6'd32; wr_data = 16'hDEAD; poked = 1;
      end
      if (sent == abort_at) begin
        load_abort = 1'b1; in_valid = 1'b1;
      end
      ok = in_valid && in_ready;
      tick;
      wr_en = 1'b0;
      if (load_abort) begin
        load_abort = 1'b0;
        break;
      end
      if (ok) sent++;
    end
    in_valid = 1'b0;
    if (guard >= 2000) check("load_budget", guard, 0);
    tick;
    tick;
    nacc = (abort_at >= 0) ? abort_at : byte_q.size();
    nw = nacc / 2;
    if (nw > int'(cnt)) nw = int'(cnt);
    sum = '0;
    for (int i = 0; i < nw; i++) begin
      a = base + 6'(i);
      mem_m[a] = {byte_q[2*i+1], byte_q[2*i]};
      sum += {byte_q[2*i+1], byte_q[2*i]};
    end
    check("load_sum", load_sum, sum);
    check("load_done_pulses", done_cnt - d0, (abort_at >= 0) ? 0 : 1);
    check("busy_after_load", busy, 0);
    if (poke) check("wr_reject_pulses", rej_cnt - r0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [6:0] rc;
    vecs[0] = '{6'd1,  16'h1234, 16'h1234};
    vecs[1] = '{6'd2,  16'hFFFF, 16'hFFFF};
    vecs[2] = '{6'd3,  16'h0001, 16'h0001};
    vecs[3] = '{6'd8,  16'h8000, 16'h8000};
    vecs[4] = '{6'd31, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{6'd32, 16'hA5A5, 16'hA5A5};
    vecs[6] = '{6'd0,  16'hBEEF, 16'hBEEF};
    vecs[7] = '{6'd63, 16'hC0DE, 16'hC0DE};

    // Reset values and clear duration
    tick;
    check("rst_rd_data", rd_data, 0);
    check("rst_load_sum", load_sum, 0);
    check("rst_load_done", load_done, 0);
    check("rst_wr_reject", wr_reject, 0);
    check("rst_busy", busy, 1);
    tick;
    reset = 1'b0;
    wait_clear;
    rd_addr = 6'd17;
    tick;
    check("rd17_after_clear", rd_data, 0);
    in_valid = 1'b1;
    #1;
    check("in_ready_idle", in_ready, 0);
    in_valid = 1'b0;

    // Read-during-write returns old data
    rd_addr = 6'd5; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hA1B2;
    tick;
    check("rdw_old", rd_data, 0);
    wr_en = 1'b0;
    tick;
    check("rdw_new", rd_data, 16'hA1B2);
    mem_m[5] = 16'hA1B2;

    // Table of direct writes, then readback
    foreach (vecs[i]) begin
      wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      tick;
      mem_m[vecs[i].addr] = vecs[i].data;
    end
    wr_en = 1'b0;
    foreach (vecs[i]) begin
      rd_addr = vecs[i].addr;
      tick;
      check("table_readback", rd_data, vecs[i].exp);
    end

    // Wrapping load, steady valid
    byte_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    run_load(6'd62, 7'd3, -1, 1'b0, 1'b0);
    check("wrap_sum_const", load_sum, 16'd6);
    read_all("mem_after_wrap_load");

    // Zero-count load
    load_base = 6'd7; load_count = '0; load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("zero_busy", busy, 0);
    check("zero_done", load_done, 1);
    check("zero_sum", load_sum, 0);
    tick;
    check("zero_done_pulse_end", load_done, 0);

    // Same load with random valid gaps, after dirtying the target words
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 6'(62 + i); wr_data = 16'hFFFF;
      tick;
    end
    wr_en = 1'b0;
    run_load(6'd62, 7'd3, -1, 1'b1, 1'b0);
    read_all("mem_after_random_valid");

    // Abort after three bytes with a rejected direct write
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(6'd10, 7'd2, 3, 1'b0, 1'b1);
    read_all("mem_after_abort");

    // Random loads
    for (int k = 0; k < 6; k++) begin
      rc = 7'($urandom_range(1, 4));
      byte_q = {};
      for (int i = 0; i < 2 * int'(rc); i++) byte_q.push_back(8'($urandom));
      run_load(6'($urandom), rc,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * int'(rc) - 1)) : -1,
               1'b1, k == 2);
    end
    read_all("mem_after_random_loads");

    // Reset in the middle of a load
    d0 = done_cnt;
    load_base = 6'd20; load_count = 7'd3; load_start = 1'b1;
    tick;
    load_start = 1'b0;
    in_valid = 1'b1; in_byte = 8'h55;
    tick;
    in_byte = 8'h66;
    tick;
    in_valid = 1'b0;
    check("midload_sum", load_sum, 16'h6655);
    reset = 1'b1;
    tick;
    check("midreset_busy", busy, 1);
    check("midreset_sum", load_sum, 0);
    check("midreset_done", load_done, 0);
    reset = 1'b0;
    wait_clear;
    tick;
    check("midreset_no_done", done_cnt - d0, 0);
    read_all("mem_after_midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
